global_pool_gen: RTL and testbench

GLOBAL_POOL_GEN -- requirements
Module: global_pool_gen

---
 rtl/global_pool_gen.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_global_pool_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_pool_gen.sv
// global_pool_gen: global average / max pooling over a square spatial map
// with per-class accumulation, a shift/saturate output stage and an output
// FIFO with first-word fall-through.
// Optional feature macro: GLOBAL_POOL_ROUND_EN (round-half-up before shift).
// Data path: transfer -> stage 1 (sample + position flags) -> stage 2 (class
// result) -> FIFO write, so a result is visible 2 cycles after its transfer.
module global_pool_gen #(
  parameter int DATA_W      = 12,
  parameter int OUT_W       = 8,
  parameter int MAX_DIM     = 32,
  parameter int MAX_CLASSES = 1024,
  parameter int OUT_DEPTH   = 1024,
  parameter int DW          = $clog2(MAX_DIM),
  parameter int CW          = $clog2(MAX_CLASSES),
  parameter int ACC_W       = DATA_W + 2 * DW,
  parameter int QW          = $clog2(OUT_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [DW-1:0]     dim_i,
  input  logic [CW-1:0]     classes_i,
  input  logic [4:0]        shift_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [QW-1:0]     out_count_o,
  output logic              busy_o,
  output logic              done_o
);

  // The ready threshold lets up to two results be in flight while the count
  // sits at OUT_DEPTH-2, so the storage holds one slot beyond OUT_DEPTH to
  // guarantee that no push is ever dropped.
  localparam int SLOTS = OUT_DEPTH + 1;
  localparam int PW    = $clog2(SLOTS);
  localparam logic [QW-1:0] READY_LIMIT = QW'(OUT_DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_done;
  logic [1:0]        r_mode;
  logic [DW-1:0]     r_dim;
  logic [CW-1:0]     r_classes;
  logic [4:0]        r_shift;
  logic [DW-1:0]     r_col;
  logic [CW-1:0]     r_cls;
  logic [DW-1:0]     r_row;

  logic                     r_s1_valid;
  logic signed [DATA_W-1:0] r_s1_data;
  logic                     r_s1_first_col;
  logic                     r_s1_last_col;
  logic                     r_s1_first_row;
  logic                     r_s1_last_row;
  logic                     r_s1_flast;
  logic [CW-1:0]            r_s1_cls;

  logic                    r_s2_valid;
  logic                    r_s2_flast;
  logic signed [ACC_W-1:0] r_res;
  logic signed [ACC_W-1:0] r_colsum;
  logic signed [ACC_W-1:0] r_acc [MAX_CLASSES];

  logic [OUT_W-1:0] r_mem [SLOTS];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [QW-1:0]    r_count;

  logic                    w_in_ready;
  logic                    w_xfer;
  logic                    w_last_col;
  logic                    w_last_cls;
  logic                    w_last_row;
  logic                    w_frame_last;
  logic                    w_bypass;
  logic                    w_is_max;
  logic signed [ACC_W-1:0] w_s1_ext;
  logic signed [ACC_W-1:0] w_acc_rd;
  logic signed [ACC_W-1:0] w_col_comb;
  logic signed [ACC_W-1:0] w_row_comb;
  logic [OUT_W-1:0]        w_sat;
  logic                    w_push;
  logic                    w_pop;

  // Circular pointer advance over the non-power-of-two slot count.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(SLOTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_in_ready   = (r_state == ST_RUN) && (r_count <= READY_LIMIT);
  assign w_xfer       = in_valid_i && w_in_ready && !start_i;
  assign w_last_col   = (r_col == r_dim);
  assign w_last_cls   = (r_cls == r_classes);
  assign w_last_row   = (r_row == r_dim);
  assign w_frame_last = w_last_col && w_last_cls && w_last_row;
  assign w_bypass     = r_mode[1];
  assign w_is_max     = (r_mode == 2'd1);
  assign w_s1_ext     = ACC_W'(r_s1_data);
  assign w_acc_rd     = r_acc[r_s1_cls];

  // Control FSM: config latch, frame position counters, state and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_mode    <= 2'd0;
      r_dim     <= '0;
      r_classes <= '0;
      r_shift   <= 5'd0;
      r_col     <= '0;
      r_cls     <= '0;
      r_row     <= '0;
    end else begin
      r_done <= 1'b0;
      if (start_i) begin
        r_mode    <= mode_i;
        r_dim     <= dim_i;
        r_classes <= classes_i;
        r_shift   <= shift_i;
        r_col     <= '0;
        r_cls     <= '0;
        r_row     <= '0;
        r_state   <= ST_RUN;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_RUN: begin
            if (w_xfer) begin
              if (!w_last_col) begin
                r_col <= r_col + DW'(1);
              end else begin
                r_col <= '0;
                if (!w_last_cls) begin
                  r_cls <= r_cls + CW'(1);
                end else begin
                  r_cls <= '0;
                  r_row <= w_last_row ? '0 : r_row + DW'(1);
                end
              end
              if (w_frame_last) begin
                r_state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (r_s2_valid && r_s2_flast) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage 1: capture the transferred sample with its position in the frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid     <= 1'b0;
      r_s1_data      <= '0;
      r_s1_first_col <= 1'b0;
      r_s1_last_col  <= 1'b0;
      r_s1_first_row <= 1'b0;
      r_s1_last_row  <= 1'b0;
      r_s1_flast     <= 1'b0;
      r_s1_cls       <= '0;
    end else if (start_i) begin
      r_s1_valid <= 1'b0;
      r_s1_flast <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_data      <= $signed(in_data_i);
        r_s1_first_col <= (r_col == '0);
        r_s1_last_col  <= w_last_col;
        r_s1_first_row <= (r_row == '0);
        r_s1_last_row  <= w_last_row;
        r_s1_flast     <= w_frame_last;
        r_s1_cls       <= r_cls;
      end
    end
  end

  // Combine the sample into the running column value, then into the class value.
  always_comb begin
    w_col_comb = w_s1_ext;
    w_row_comb = w_col_comb;
    if (r_s1_first_col) begin
      w_col_comb = w_s1_ext;
    end else if (w_is_max) begin
      w_col_comb = (w_s1_ext > r_colsum) ? w_s1_ext : r_colsum;
    end else begin
      w_col_comb = r_colsum + w_s1_ext;
    end
    if (r_s1_first_row) begin
      w_row_comb = w_col_comb;
    end else if (w_is_max) begin
      w_row_comb = (w_col_comb > w_acc_rd) ? w_col_comb : w_acc_rd;
    end else begin
      w_row_comb = w_acc_rd + w_col_comb;
    end
  end

  // Stage 2: running column value and the finished class (or bypass) result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_flast <= 1'b0;
      r_res      <= '0;
      r_colsum   <= '0;
    end else if (start_i) begin
      r_s2_valid <= 1'b0;
      r_s2_flast <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid && (w_bypass || (r_s1_last_col && r_s1_last_row));
      r_s2_flast <= r_s1_valid && r_s1_flast;
      if (r_s1_valid) begin
        r_colsum <= w_col_comb;
        r_res    <= w_bypass ? w_s1_ext : w_row_comb;
      end
    end
  end

  // Per-class accumulator store; row 0 overwrites, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (r_s1_valid && r_s1_last_col && !w_bypass) begin
      r_acc[r_s1_cls] <= w_row_comb;
    end
  end

`ifdef GLOBAL_POOL_ROUND_EN
  // Wide enough that the rounding bias never wraps for any 5-bit shift.
  localparam int SW = ACC_W + 33;
  logic signed [SW-1:0] w_rnd_bias;
  logic signed [SW-1:0] w_shifted;

  // Round half up: add 2^(shift-1) before the arithmetic shift.
  always_comb begin
    if (r_shift != 5'd0) begin
      w_rnd_bias = SW'(1) <<< (r_shift - 5'd1);
    end else begin
      w_rnd_bias = '0;
    end
    w_shifted = (SW'(r_res) + w_rnd_bias) >>> r_shift;
  end
`else
  localparam int SW = ACC_W;
  logic signed [SW-1:0] w_shifted;

  // Truncating arithmetic shift (rounds toward minus infinity).
  always_comb begin
    w_shifted = r_res >>> r_shift;
  end
`endif

  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 << (OUT_W - 1)));

  // Clamp the shifted result into the signed output range.
  always_comb begin
    if (w_shifted > SAT_HI) begin
      w_sat = SAT_HI[OUT_W-1:0];
    end else if (w_shifted < SAT_LO) begin
      w_sat = SAT_LO[OUT_W-1:0];
    end else begin
      w_sat = w_shifted[OUT_W-1:0];
    end
  end

  assign w_push = r_s2_valid;
  assign w_pop  = (r_count != '0) && out_ready_i;

  // FIFO pointers and occupancy; start_i empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (start_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + QW'(1);
        2'b01:   r_count <= r_count - QW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk_i) begin
    if (w_push && !start_i) begin
      r_mem[r_wr_ptr] <= w_sat;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = (r_count != '0);
  assign out_data_o  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign out_count_o = r_count;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_global_pool_gen.sv
// Self-checking bench for global_pool_gen: fixed vector table, randomized
// frames against an arithmetic reference model, and hand-written sequences
// for latency, backpressure, abort and mid-frame reset.
module tb_global_pool_gen;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic [4:0] dim_i;
  logic [9:0] classes_i;
  logic [4:0] shift_i;
  logic [11:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [2:0] out_count_o;
  logic       busy_o;
  logic       done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int g_samp[$];
  int g_exp[$];

  typedef struct {
    logic [1:0] mode;
    int dim;
    int cls;
    int shift;
    int n;
    int s[12];
    int ne;
    int e[3];
  } vec_t;

  vec_t tv[6];

  global_pool_gen #(.OUT_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .dim_i(dim_i), .classes_i(classes_i), .shift_i(shift_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_count_o(out_count_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Shift by floor division (optionally with half-up bias) then clamp.
  function automatic int post(input longint v, input int sh);
    longint p;
    longint q;
    p = longint'(1) << sh;
`ifdef GLOBAL_POOL_ROUND_EN
    if (sh > 0) v = v + p / 2;
`endif
    if (v >= 0) q = v / p;
    else q = -((-v + p - 1) / p);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  // Expected results for the frame held in g_samp.
  function automatic void build_model(input logic [1:0] m, input int d, input int c, input int sh);
    int n;
    int nc;
    longint v;
    g_exp.delete();
    n = d + 1;
    nc = c + 1;
    if (m[1]) begin
      foreach (g_samp[i]) g_exp.push_back(post(g_samp[i], sh));
    end else begin
      for (int k = 0; k < nc; k++) begin
        v = g_samp[k * n];
        for (int r = 0; r < n; r++) begin
          for (int x = 0; x < n; x++) begin
            int s;
            s = g_samp[r * nc * n + k * n + x];
            if (m == 2'd0) begin
              if (!(r == 0 && x == 0)) v = v + s;
            end else begin
              if (s > v) v = s;
            end
          end
        end
        g_exp.push_back(post(v, sh));
      end
    end
  endfunction

  // Start a frame, stream g_samp with random gaps, collect and compare to g_exp.
  task automatic run_frame(input logic [1:0] m, input int d, input int c, input int sh,
                           input int hold, input string nm);
    int idx;
    int cyc;
    int dones;
    int viol;
    int outs[$];
    bit fin;
    idx = 0; cyc = 0; dones = 0; viol = 0; fin = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; mode_i = m; dim_i = 5'(d); classes_i = 10'(c); shift_i = 5'(sh);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    mode_i = 2'($urandom); dim_i = 5'($urandom); classes_i = 10'($urandom); shift_i = 5'($urandom);
    chk({nm, " count_after_start"}, int'(out_count_o), 0);
    chk({nm, " busy_after_start"}, int'(busy_o), 1);
    while (!fin && cyc < 20000) begin
      if (done_o) dones++;
      if (in_ready_o && (!busy_o || out_count_o > 3'(DEPTH - 2))) viol++;
      if (hold > 0 && cyc == hold - 1) begin
        chk({nm, " ready_low_when_full"}, int'(in_ready_o), 0);
        chk({nm, " count_at_least_3"}, int'(out_count_o >= 3'd3), 1);
      end
      if (idx == g_samp.size() && !busy_o && !out_valid_o) begin
        fin = 1'b1;
      end else begin
        out_ready_i = (cyc < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid_o && out_ready_i) outs.push_back(int'($signed(out_data_o)));
        if (idx < g_samp.size()) begin
          in_valid_i = ($urandom_range(0, 3) != 0);
          in_data_i = 12'(g_samp[idx]);
          if (in_valid_i && in_ready_o) idx++;
        end else begin
          in_valid_i = 1'b0;
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: sent %0d of %0d, got %0d results", nm, idx, g_samp.size(), outs.size());
    end
    chk({nm, " result_count"}, outs.size(), g_exp.size());
    for (int i = 0; i < outs.size() && i < g_exp.size(); i++) begin
      chk($sformatf("%s result[%0d]", nm, i), outs[i], g_exp[i]);
    end
    chk({nm, " done_pulses"}, dones, 1);
    chk({nm, " ready_rule_violations"}, viol, 0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 2'd0; dim_i = 5'd0; classes_i = 10'd0;
    shift_i = 5'd0; in_data_i = 12'd0; in_valid_i = 1'b0; out_ready_i = 1'b0;

    tv[0] = '{mode: 2'd0, dim: 1, cls: 1, shift: 2, n: 8,
              s: '{4, 4, -8, -8, 4, 4, -8, -8, 0, 0, 0, 0}, ne: 2, e: '{4, -8, 0}};
    tv[1] = '{mode: 2'd1, dim: 2, cls: 0, shift: 0, n: 9,
              s: '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0}, ne: 1, e: '{8, 0, 0}};
    tv[2] = '{mode: 2'd2, dim: 0, cls: 1, shift: 4, n: 2,
              s: '{2047, -2048, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, ne: 2, e: '{127, -128, 0}};
`ifdef GLOBAL_POOL_ROUND_EN
    tv[3] = '{mode: 2'd0, dim: 0, cls: 0, shift: 1, n: 1,
              s: '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, ne: 1, e: '{2, 0, 0}};
`else
    tv[3] = '{mode: 2'd0, dim: 0, cls: 0, shift: 1, n: 1,
              s: '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, ne: 1, e: '{1, 0, 0}};
`endif
    tv[4] = '{mode: 2'd0, dim: 1, cls: 0, shift: 0, n: 4,
              s: '{-5, 7, 100, -2000, 0, 0, 0, 0, 0, 0, 0, 0}, ne: 1, e: '{-128, 0, 0}};
    tv[5] = '{mode: 2'd1, dim: 1, cls: 2, shift: 0, n: 12,
              s: '{-3, -9, 5, 1, -100, -50, -7, -2, 0, 3, -60, -51}, ne: 3, e: '{-2, 5, -50}};

    // Reset values
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst in_ready", int'(in_ready_o), 0);
    chk("rst out_valid", int'(out_valid_o), 0);
    chk("rst out_data", int'(out_data_o), 0);
    chk("rst out_count", int'(out_count_o), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle in_ready", int'(in_ready_o), 0);

    // Fixed vector table
    for (int t = 0; t < 6; t++) begin
      g_samp.delete();
      g_exp.delete();
      for (int i = 0; i < tv[t].n; i++) g_samp.push_back(tv[t].s[i]);
      for (int i = 0; i < tv[t].ne; i++) g_exp.push_back(tv[t].e[i]);
      run_frame(tv[t].mode, tv[t].dim, tv[t].cls, tv[t].shift, 0, $sformatf("vec%0d", t));
    end

    // Latency: result visible exactly 2 cycles after its transfer
    @(negedge clk_i);
    start_i = 1'b1; mode_i = 2'd2; dim_i = 5'd0; classes_i = 10'd0; shift_i = 5'd0;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 12'd77;
    chk("lat ready", int'(in_ready_o), 1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("lat valid+1", int'(out_valid_o), 0);
    chk("lat busy drain", int'(busy_o), 1);
    @(negedge clk_i);
    chk("lat valid+2early", int'(out_valid_o), 0);
    @(negedge clk_i);
    chk("lat valid+2", int'(out_valid_o), 1);
    chk("lat data", int'(out_data_o), 77);
    chk("lat done", int'(done_o), 1);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    chk("lat done_clear", int'(done_o), 0);
    chk("lat idle", int'(busy_o), 0);
    chk("lat popped", int'(out_count_o), 0);

    // Backpressure: FIFO fills with out_ready low, nothing lost after release
    g_samp.delete();
    for (int i = 0; i < 9; i++) g_samp.push_back(int'($urandom_range(0, 4095)) - 2048);
    build_model(2'd2, 2, 0, 3);
    run_frame(2'd2, 2, 0, 3, 20, "bp");

    // Randomized frames against the model
    for (int f = 0; f < 14; f++) begin
      logic [1:0] m;
      int d;
      int c;
      int sh;
      m = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 5);
      c = $urandom_range(0, 4);
      sh = (f % 4 == 3) ? $urandom_range(0, 31) : $urandom_range(0, 12);
      g_samp.delete();
      for (int i = 0; i < (d + 1) * (d + 1) * (c + 1); i++)
        g_samp.push_back(int'($urandom_range(0, 4095)) - 2048);
      build_model(m, d, c, sh);
      run_frame(m, d, c, sh, 0, $sformatf("rnd%0d", f));
    end

    // Full-size frames at the extremes: no accumulator overflow
    g_samp.delete();
    for (int i = 0; i < 1024; i++) g_samp.push_back(2047);
    build_model(2'd0, 31, 0, 15);
    run_frame(2'd0, 31, 0, 15, 0, "big_avg");
    g_samp.delete();
    for (int i = 0; i < 1024; i++) g_samp.push_back(-2048);
    build_model(2'd0, 31, 0, 14);
    run_frame(2'd0, 31, 0, 14, 0, "big_neg");

    // Abort: start mid-frame, the new frame must match a clean run
    @(negedge clk_i);
    start_i = 1'b1; mode_i = 2'd2; dim_i = 5'd2; classes_i = 10'd0; shift_i = 5'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1; in_data_i = 12'(i + 50);
      @(negedge clk_i);
    end
    g_samp.delete();
    for (int i = 0; i < 18; i++) g_samp.push_back(int'($urandom_range(0, 400)) - 200);
    build_model(2'd0, 2, 1, 2);
    run_frame(2'd0, 2, 1, 2, 0, "abort");

    // Reset mid-frame: partial results discarded, no output afterwards
    begin
      int seen;
      seen = 0;
      @(negedge clk_i);
      start_i = 1'b1; mode_i = 2'd2; dim_i = 5'd3; classes_i = 10'd1; shift_i = 5'd0;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_valid_i = 1'b1; in_data_i = 12'(i + 9);
        @(negedge clk_i);
      end
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (out_valid_o) seen++;
        @(negedge clk_i);
      end
      out_ready_i = 1'b0;
      chk("rstmid outputs", seen, 0);
      chk("rstmid busy", int'(busy_o), 0);
      chk("rstmid count", int'(out_count_o), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
